// File: rtl/serdes_pkg.sv
// Shared serdes definitions: deserializer FSM state type and the constants
// common to the serializer/deserializer pair (default word width, sync word).
// Ports: none (package).
package serdes_pkg;

  // Word-alignment state of the deserializer.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } deser_state_t;

  // Defaults shared by both ends of the link.
  localparam int          SERDES_WIDTH     = 2;
  localparam int          SERDES_LOGWIDTH  = 1;
  localparam logic [1:0]  SERDES_SYNC_WORD = 2'b10;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel converter with sync-word alignment (HUNT/LOCKED FSM).
// Ports: clk, reset (async, active-high), data_i (serial, LSB first),
//        resync_i (drop lock), data_o/valid_o (word + 1-cycle strobe), locked_o.
module deserializer
  import serdes_pkg::*;
#(
  parameter int                 WIDTH     = SERDES_WIDTH,
  parameter int                 LOGWIDTH  = SERDES_LOGWIDTH,
  parameter logic [WIDTH-1:0]   SYNC_WORD = SERDES_SYNC_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_i,
  input  logic              resync_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o,
  output logic              locked_o
);

  deser_state_t         state;
  logic [LOGWIDTH-1:0]  cnt;
  logic [WIDTH-1:0]     shift;
  logic [WIDTH-1:0]     shift_next;
  logic                 word_done;

  // New bit enters at the MSB; after WIDTH samples bit 0 is the earliest bit.
  // Comparisons use shift_next so the bit sampled on this edge is included.
  assign shift_next = {data_i, shift[WIDTH-1:1]};
  assign word_done  = (cnt == LOGWIDTH'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      cnt      <= '0;
      shift    <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      shift   <= shift_next;
      valid_o <= 1'b0;
      case (state)
        HUNT: begin
          // resync_i is deliberately ignored while hunting.
          if (shift_next == SYNC_WORD) begin
            state    <= LOCKED;
            cnt      <= '0;
            locked_o <= 1'b1;
          end
        end
        LOCKED: begin
          if (resync_i) begin
            // Resync wins over a completing word: partial/complete word dropped.
            state    <= HUNT;
            cnt      <= '0;
            locked_o <= 1'b0;
          end else if (word_done) begin
            // Explicit wrap so non-power-of-two widths count correctly.
            cnt <= '0;
            if (shift_next != SYNC_WORD) begin
              data_o  <= shift_next;
              valid_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + LOGWIDTH'(1);
          end
        end
        default: begin
          state    <= HUNT;
          cnt      <= '0;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
